ect_quad_demod: RTL

- Quadrature (I/Q) digital demodulator directly downstream of the AD9240 capture stage.
- Consumes one two's-complement 14-bit sample per CLK, with the ADC sampling at 4x the excitation frequency.
- Multiplies each sample by the reference sequences cos = {+1,0,-1,0} and sin = {0,+1,0,-1} and accumulates over SampNum samples per measurement frame.
- Delivers signed I/Q sums plus a frame overflow flag to the image-reconstruction/readout logic.

---
 rtl/ect_quad_demod.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/ect_quad_demod.sv
// Quadrature I/Q demodulator: correlates 4x-oversampled ADC data with {+1,0,-1,0}/{0,+1,0,-1}.
// Optional macro ECT_AMP_OUT_EN adds the registered |I|+|Q| magnitude output AmpOut.
module ect_quad_demod #(
    parameter int unsigned SampNum = 200,
    parameter int unsigned SkipNum = 4,
    parameter int unsigned AccW    = 24
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            Enable,
    input  logic            Start,
    input  logic [13:0]     DataIn,
    input  logic            OverFlowIn,
    output logic [AccW-1:0] IOut,
    output logic [AccW-1:0] QOut,
    output logic            OverFlow,
    output logic            Busy,
`ifdef ECT_AMP_OUT_EN
    output logic [AccW:0]   AmpOut,
`endif
    output logic            Done
);

    localparam int unsigned CntMax  = (SampNum > SkipNum) ? SampNum : SkipNum;
    localparam int unsigned CntW    = $clog2(CntMax);
    localparam bit          HasSkip = (SkipNum != 0);
    localparam logic [CntW-1:0] AccLoad  = CntW'(SampNum - 1);
    localparam logic [CntW-1:0] SkipLoad = HasSkip ? CntW'(SkipNum - 1) : '0;

    typedef enum logic [1:0] {StIdle, StSkip, StAcc, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      phase_q, phase_d;
    logic [AccW-1:0] i_acc_q, i_acc_d;
    logic [AccW-1:0] q_acc_q, q_acc_d;
    logic            ovf_acc_q, ovf_acc_d;
    logic [AccW-1:0] i_out_q, i_out_d;
    logic [AccW-1:0] q_out_q, q_out_d;
    logic            ovf_out_q, ovf_out_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [AccW-1:0] x;

    assign x = {{(AccW-14){DataIn[13]}}, DataIn};

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (Start && Enable) begin
                    state_d = HasSkip ? StSkip : StAcc;
                end
            end
            StSkip: begin
                if (!Enable) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    state_d = StAcc;
                end
            end
            StAcc: begin
                if (!Enable) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        i_acc_d   = i_acc_q;
        q_acc_d   = q_acc_q;
        ovf_acc_d = ovf_acc_q;
        i_out_d   = i_out_q;
        q_out_d   = q_out_q;
        ovf_out_d = ovf_out_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (Start && Enable) begin
                    i_acc_d   = '0;
                    q_acc_d   = '0;
                    ovf_acc_d = 1'b0;
                    phase_d   = 2'd0;
                    cnt_d     = HasSkip ? SkipLoad : AccLoad;
                    busy_d    = 1'b1;
                end
            end
            StSkip: begin
                if (Enable) begin
                    cnt_d = (cnt_q == '0) ? AccLoad : cnt_q - CntW'(1);
                end
            end
            StAcc: begin
                if (Enable) begin
                    unique case (phase_q)
                        2'd0:    i_acc_d = i_acc_q + x;
                        2'd1:    q_acc_d = q_acc_q + x;
                        2'd2:    i_acc_d = i_acc_q - x;
                        default: q_acc_d = q_acc_q - x;
                    endcase
                    ovf_acc_d = ovf_acc_q | OverFlowIn;
                    phase_d   = phase_q + 2'd1;
                    cnt_d     = (cnt_q == '0) ? '0 : cnt_q - CntW'(1);
                end
            end
            StDone: begin
                if (Enable) begin
                    i_out_d   = i_acc_q;
                    q_out_d   = q_acc_q;
                    ovf_out_d = ovf_acc_q;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                end
            end
            default: ;
        endcase
        // Abort: drop the frame silently, leave the published outputs untouched
        if (state_q != StIdle && !Enable) begin
            busy_d    = 1'b0;
            done_d    = 1'b0;
            i_acc_d   = '0;
            q_acc_d   = '0;
            ovf_acc_d = 1'b0;
            phase_d   = 2'd0;
            cnt_d     = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q     <= '0;
            phase_q   <= 2'd0;
            i_acc_q   <= '0;
            q_acc_q   <= '0;
            ovf_acc_q <= 1'b0;
            i_out_q   <= '0;
            q_out_q   <= '0;
            ovf_out_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            i_acc_q   <= i_acc_d;
            q_acc_q   <= q_acc_d;
            ovf_acc_q <= ovf_acc_d;
            i_out_q   <= i_out_d;
            q_out_q   <= q_out_d;
            ovf_out_q <= ovf_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

`ifdef ECT_AMP_OUT_EN
    logic [AccW:0] amp_q, amp_d;
    logic [AccW:0] i_ext, q_ext, i_abs, q_abs;

    // One extra bit so the most negative accumulator value has a representable magnitude
    always_comb begin
        i_ext = {i_acc_q[AccW-1], i_acc_q};
        q_ext = {q_acc_q[AccW-1], q_acc_q};
        i_abs = i_acc_q[AccW-1] ? ((AccW+1)'(0) - i_ext) : i_ext;
        q_abs = q_acc_q[AccW-1] ? ((AccW+1)'(0) - q_ext) : q_ext;
        amp_d = amp_q;
        if (state_q == StDone && Enable) begin
            amp_d = i_abs + q_abs;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            amp_q <= '0;
        end else begin
            amp_q <= amp_d;
        end
    end

    assign AmpOut = amp_q;
`endif

    assign IOut     = i_out_q;
    assign QOut     = q_out_q;
    assign OverFlow = ovf_out_q;
    assign Busy     = busy_q;
    assign Done     = done_q;

endmodule
